debug_sequencer: RTL and testbench
==================================

DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 Parameter DUMP_BYTES, default 16: number of datapath snapshot bytes per dump frame (1..64).
REQ-002 Parameter RST_CYCLES, default 4: dp_reset pulse length in clk cycles (1..15).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  received UART byte, valid when rx_data_rdy=1.
REQ-006 rx_data_rdy  in  1  one-cycle strobe per received byte.
REQ-007 tx_busy  in  1  UART transmitter busy; rises the cycle after an accepted tx_write.
REQ-008 dp_bus  in  DUMP_BYTES*8  datapath debug snapshot (registers/PC/latches).
REQ-009 dp_halt  in  1  datapath fetched HALT; level.
REQ-010 dp_clk_en  out  1  datapath clock enable; one datapath cycle per high clk cycle.
REQ-011 dp_reset  out  1  datapath synchronous reset.
REQ-012 tx_data  out  8  byte to transmit.
REQ-013 tx_write  out  1  one-cycle transmit strobe.
REQ-014 running  out  1  high while in RUN state.

Function
REQ-015 States SHALL be IDLE, RESET, STEP, RUN, LOAD, SEND, WAIT; all outputs registered.
REQ-016 IDLE: rx byte 0x52 'R' -> RESET; 0x53 'S' -> STEP; 0x43 'C' -> RUN; 0x44 'D' -> LOAD; any other byte ignored, stay IDLE.
REQ-017 RESET: dp_reset=1 for exactly RST_CYCLES cycles, cycle counter cleared to 0, then IDLE; no dump.
REQ-018 STEP: dp_clk_en=1 for exactly one cycle, counter +1, then LOAD.
REQ-019 RUN: dp_clk_en=1 every cycle, counter +1 per cycle; exits to LOAD the cycle after dp_halt=1 or any rx_data_rdy (byte value discarded); dp_clk_en=0 from that cycle.
REQ-020 RUN entered with dp_halt already 1: exactly one dp_clk_en cycle then LOAD.
REQ-021 Cycle counter SHALL be 32 bits, unsigned, wraps 0xFFFFFFFF -> 0 without flag.
REQ-022 LOAD: in one cycle capture {dp_bus, counter} into a frame shift register; later dp_bus changes do not affect the frame.
REQ-023 Frame order: counter bytes 0..3 LSB first, then dp_bus[7:0], dp_bus[15:8], ... up to DUMP_BYTES bytes; total DUMP_BYTES+4 bytes.
REQ-024 SEND: when tx_busy=0, drive tx_data with current byte and pulse tx_write one cycle, go WAIT; while tx_busy=1, hold.
REQ-025 WAIT: stay at least one cycle, then until tx_busy=0; next byte -> SEND, last byte -> IDLE.
REQ-026 tx_write SHALL never assert while tx_busy=1 or on consecutive cycles.
REQ-027 rx bytes arriving in RESET, STEP, LOAD, SEND, WAIT are dropped (no queue).
REQ-028 dp_reset and dp_clk_en SHALL never be high in the same cycle.
REQ-029 running=1 exactly while state=RUN.

Reset
REQ-030 rst=1 SHALL force IDLE, counter=0, frame register=0, byte index=0, and dp_clk_en, dp_reset, tx_write, running, tx_data all 0 on the next edge.
REQ-031 rst mid-frame aborts the dump; the next frame starts from byte 0.
REQ-032 rst has priority over rx_data_rdy in the same cycle.

Structure
REQ-033 Command codes (0x52, 0x53, 0x43, 0x44), state encoding and frame header length (4) SHALL live in shared package debug_pkg.
REQ-034 One sub-module dbg_tx_serializer SHALL own the frame shift register, byte index and SEND/WAIT handshake; the top FSM issues a load/start and observes done.

Verification
REQ-035 rst, then 'S' -> one dp_clk_en pulse, then 20 bytes with counter bytes 01 00 00 00 followed by dp_bus bytes LSB first.
REQ-036 'C' with dp_halt raised after 10 dp_clk_en cycles -> exactly 11 enabled cycles, frame header 0B 00 00 00.
REQ-037 'R' after run -> dp_reset high exactly 4 cycles, no tx_write; following 'D' -> header 00 00 00 00.
REQ-038 tx_busy held high 50 cycles per byte -> tx_write only when tx_busy=0, never back-to-back, all 20 bytes in order.
REQ-039 Counter preset 0xFFFFFFFF (force) then 'S' -> header 00 00 00 00; byte 0x41 in IDLE and 'S' during SEND -> ignored.
REQ-040 rst asserted at byte 7 of a frame -> all outputs 0 next cycle; subsequent 'D' sends full frame from byte 0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared command codes, frame geometry and state encoding for the debug
// sequencer and its transmit serializer.
package debug_pkg;

  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RUN   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'

  localparam int HDR_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_STEP,
    S_RUN,
    S_LOAD,
    S_SEND,
    S_WAIT
  } state_e;

endpackage

// File: rtl/dbg_tx_serializer.sv
// Captures one dump frame ({dp_bus, counter}) and sends it LSB byte first
// over a busy/write UART handshake, pulsing done_o after the last byte.
module dbg_tx_serializer
  import debug_pkg::*;
#(
  parameter int DUMP_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [DUMP_BYTES*8-1:0] dp_bus_i,
  input  logic [31:0]             cnt_i,
  input  logic                    tx_busy,
  output logic [7:0]              tx_data,
  output logic                    tx_write,
  output logic                    done_o
);

  localparam int FRAME_BYTES = DUMP_BYTES + HDR_BYTES;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  state_e                   tx_state_q, tx_state_d;
  logic [FRAME_BYTES*8-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     wait_min_q, wait_min_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_write_q, tx_write_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    tx_state_d = tx_state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    wait_min_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_write_d = 1'b0;
    done_o     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (load_i) begin
          frame_d    = {dp_bus_i, cnt_i};
          idx_d      = '0;
          tx_state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = frame_q[7:0];
          tx_write_d = 1'b1;
          wait_min_d = 1'b1;
          tx_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // tx_busy only rises one cycle after the write, so the first WAIT
        // cycle never looks at it.
        if (!wait_min_q && !tx_busy) begin
          if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
            done_o     = 1'b1;
            idx_d      = '0;
            tx_state_d = S_IDLE;
          end else begin
            frame_d    = frame_q >> 8;
            idx_d      = idx_q + IDX_W'(1);
            tx_state_d = S_SEND;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the frame register is an ordinary flop bank, not a RAM, so it is
    // cleared on reset along with the rest of the state.
    if (rst) begin
      tx_state_q <= S_IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      wait_min_q <= 1'b0;
      tx_data_q  <= '0;
      tx_write_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      wait_min_q <= wait_min_d;
      tx_data_q  <= tx_data_d;
      tx_write_q <= tx_write_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_write = tx_write_q;

endmodule

// File: rtl/debug_sequencer.sv
// UART-driven debug controller: resets, single-steps or free-runs a datapath
// and dumps {cycle counter, dp_bus} as a byte frame after each step/run/dump.
module debug_sequencer
  import debug_pkg::*;
#(
  parameter int DUMP_BYTES = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_rdy,
  input  logic                    tx_busy,
  input  logic [DUMP_BYTES*8-1:0] dp_bus,
  input  logic                    dp_halt,
  output logic                    dp_clk_en,
  output logic                    dp_reset,
  output logic [7:0]              tx_data,
  output logic                    tx_write,
  output logic                    running
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic        dp_clk_en_q, dp_clk_en_d;
  logic        dp_reset_q, dp_reset_d;
  logic        running_q, running_d;
  logic        ser_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rx_data_rdy) begin
          case (rx_data)
            CMD_RESET: begin
              state_d   = S_RESET;
              rst_cnt_d = 4'(RST_CYCLES - 1);
            end
            CMD_STEP: state_d = S_STEP;
            CMD_RUN:  state_d = S_RUN;
            CMD_DUMP: state_d = S_LOAD;
            default:  ;
          endcase
        end
      end
      S_RESET: begin
        cnt_d = '0;
        if (rst_cnt_q == 4'd0) state_d = S_IDLE;
        else                   rst_cnt_d = rst_cnt_q - 4'd1;
      end
      S_STEP: begin
        cnt_d   = cnt_q + 32'd1;
        state_d = S_LOAD;
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (dp_halt || rx_data_rdy) state_d = S_LOAD;
      end
      S_LOAD:         state_d = S_SEND;
      S_SEND, S_WAIT: if (ser_done) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up exactly with the state they describe.
    dp_clk_en_d = (state_d == S_STEP) || (state_d == S_RUN);
    dp_reset_d  = (state_d == S_RESET);
    running_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rst_cnt_q   <= '0;
      dp_clk_en_q <= 1'b0;
      dp_reset_q  <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      dp_clk_en_q <= dp_clk_en_d;
      dp_reset_q  <= dp_reset_d;
      running_q   <= running_d;
    end
  end

  dbg_tx_serializer #(
    .DUMP_BYTES(DUMP_BYTES)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (state_q == S_LOAD),
    .dp_bus_i(dp_bus),
    .cnt_i   (cnt_q),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .tx_write(tx_write),
    .done_o  (ser_done)
  );

  assign dp_clk_en = dp_clk_en_q;
  assign dp_reset  = dp_reset_q;
  assign running   = running_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Scoreboard bench for debug_sequencer: commands push expected frames, a
// negedge monitor pops and compares every transmitted byte.
module tb_debug_sequencer;
  import debug_pkg::*;

  localparam int DUMP_BYTES  = 16;
  localparam int RST_CYCLES  = 4;
  localparam int FRAME_BYTES = DUMP_BYTES + HDR_BYTES;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [7:0]              rx_data;
  logic                    rx_data_rdy;
  logic                    tx_busy;
  logic [DUMP_BYTES*8-1:0] dp_bus;
  logic                    dp_halt;
  logic                    dp_clk_en;
  logic                    dp_reset;
  logic [7:0]              tx_data;
  logic                    tx_write;
  logic                    running;

  always #5 clk = ~clk;

  debug_sequencer #(
    .DUMP_BYTES(DUMP_BYTES),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_data_rdy(rx_data_rdy),
    .tx_busy    (tx_busy),
    .dp_bus     (dp_bus),
    .dp_halt    (dp_halt),
    .dp_clk_en  (dp_clk_en),
    .dp_reset   (dp_reset),
    .tx_data    (tx_data),
    .tx_write   (tx_write),
    .running    (running)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART transmitter model: busy for busy_len cycles starting the cycle after a write.
  int busy_len = 2;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_write)          busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Scoreboard and activity monitor
  logic [7:0] exp_q[$];
  int         en_cyc  = 0;
  int         rst_cyc = 0;
  int         run_cyc = 0;
  int         wr_cnt  = 0;
  logic       prev_wr = 1'b0;

  always @(negedge clk) begin
    if (dp_clk_en) en_cyc++;
    if (dp_reset)  rst_cyc++;
    if (running)   run_cyc++;
    if (dp_clk_en && dp_reset) begin
      n_vec++;
      n_err++;
      $display("FAIL en_reset_overlap: got both high expected at most one");
    end
    if (tx_write) begin
      wr_cnt++;
      check("tx_busy_at_write", tx_busy, 0);
      check("write_back_to_back", prev_wr, 0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got %02h expected no write", tx_data);
      end else begin
        check("frame_byte", tx_data, exp_q.pop_front());
      end
    end
    prev_wr = tx_write;
  end

  // Reference model state: the cycle counter as the datapath would see it.
  logic [31:0] cnt_model = '0;

  function automatic logic [DUMP_BYTES*8-1:0] rand_bus();
    logic [DUMP_BYTES*8-1:0] b;
    for (int i = 0; i < DUMP_BYTES; i++) b[8*i +: 8] = 8'($urandom);
    return b;
  endfunction

  task automatic push_frame(input logic [31:0] cnt, input logic [DUMP_BYTES*8-1:0] bus);
    for (int i = 0; i < HDR_BYTES; i++)  exp_q.push_back(cnt[8*i +: 8]);
    for (int j = 0; j < DUMP_BYTES; j++) exp_q.push_back(bus[8*j +: 8]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_data_rdy = 1'b1;
    tick();
    rx_data_rdy = 1'b0;
    rx_data     = 8'($urandom);
  endtask

  // Waits for the queue to drain (bounded), scrambling dp_bus once the frame
  // is under way, then lets the last handshake finish.
  task automatic wait_frame();
    int   budget  = FRAME_BYTES * (busy_len + 8) + 100;
    logic changed = 1'b0;
    while (exp_q.size() != 0 && budget > 0) begin
      if (!changed && exp_q.size() < FRAME_BYTES) begin
        dp_bus  = rand_bus();
        changed = 1'b1;
      end
      tick();
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: got %0d bytes left expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (busy_len + 4) tick();
  endtask

  task automatic do_step();
    int e0 = en_cyc;
    int r0 = run_cyc;
    push_frame(cnt_model + 32'd1, dp_bus);
    cnt_model = cnt_model + 32'd1;
    send_byte(CMD_STEP);
    wait_frame();
    check("step_en_cycles", en_cyc - e0, 1);
    check("step_running_cycles", run_cyc - r0, 0);
  endtask

  // Free-run for exactly k enabled cycles, ended by dp_halt or by an rx byte
  // seen during the k-th cycle.
  task automatic do_run(input int k, input bit by_rx);
    int e0 = en_cyc;
    int r0 = run_cyc;
    if (k == 1 && !by_rx) dp_halt = 1'b1;
    push_frame(cnt_model + 32'(k), dp_bus);
    cnt_model = cnt_model + 32'(k);
    send_byte(CMD_RUN);
    for (int i = 1; i < k; i++) tick();
    if (by_rx) begin
      rx_data     = 8'($urandom);
      rx_data_rdy = 1'b1;
      tick();
      rx_data_rdy = 1'b0;
    end else begin
      dp_halt = 1'b1;
      tick();
    end
    wait_frame();
    dp_halt = 1'b0;
    check("run_en_cycles", en_cyc - e0, k);
    check("run_running_cycles", run_cyc - r0, k);
  endtask

  task automatic do_dump();
    int e0 = en_cyc;
    push_frame(cnt_model, dp_bus);
    send_byte(CMD_DUMP);
    wait_frame();
    check("dump_en_cycles", en_cyc - e0, 0);
  endtask

  task automatic do_reset_cmd();
    int e0 = en_cyc;
    int r0 = rst_cyc;
    int w0 = wr_cnt;
    send_byte(CMD_RESET);
    repeat (RST_CYCLES + 3) tick();
    cnt_model = '0;
    check("reset_pulse_cycles", rst_cyc - r0, RST_CYCLES);
    check("reset_no_write", wr_cnt - w0, 0);
    check("reset_no_enable", en_cyc - e0, 0);
  endtask

  task automatic do_junk();
    int         e0 = en_cyc;
    int         r0 = rst_cyc;
    int         w0 = wr_cnt;
    logic [7:0] b;
    do b = 8'($urandom);
    while (b inside {CMD_RESET, CMD_STEP, CMD_RUN, CMD_DUMP});
    send_byte(b);
    repeat (5) tick();
    check("junk_activity", (en_cyc - e0) + (rst_cyc - r0) + (wr_cnt - w0), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dp_clk_en"}, dp_clk_en, 0);
    check({tag, "_dp_reset"},  dp_reset,  0);
    check({tag, "_tx_write"},  tx_write,  0);
    check({tag, "_running"},   running,   0);
    check({tag, "_tx_data"},   tx_data,   0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int e0;
    rst         = 1'b1;
    rx_data     = '0;
    rx_data_rdy = 1'b0;
    dp_halt     = 1'b0;
    dp_bus      = rand_bus();
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Single step after reset: header 01 00 00 00
    do_step();
    // Clear counter, then halt raised after 10 enabled cycles: 11 cycles, header 0B
    do_reset_cmd();
    do_run(11, 1'b0);
    // Reset after run, then dump: header 00
    do_reset_cmd();
    do_dump();
    // Halt already high on entry, and run ended by an rx byte
    do_run(1, 1'b0);
    do_run(5, 1'b1);
    // Slow transmitter
    busy_len = 50;
    do_step();
    busy_len = 2;

    // Counter wrap
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.cnt_q;
    cnt_model = 32'hFFFF_FFFF;
    do_step();

    // Non-command byte in IDLE, then 'S' in the middle of a frame
    do_junk();
    e0 = en_cyc;
    push_frame(cnt_model, dp_bus);
    send_byte(CMD_DUMP);
    budget = 500;
    while (exp_q.size() > FRAME_BYTES - 3 && budget > 0) begin
      tick();
      budget--;
    end
    send_byte(CMD_STEP);
    wait_frame();
    check("step_during_send_en", en_cyc - e0, 0);

    // Reset after byte 7 of a frame, then a complete fresh dump
    push_frame(cnt_model, dp_bus);
    send_byte(CMD_DUMP);
    budget = 500;
    while (exp_q.size() > FRAME_BYTES - 7 && budget > 0) begin
      tick();
      budget--;
    end
    check("abort_reached_byte7", exp_q.size(), FRAME_BYTES - 7);
    rst = 1'b1;
    tick();
    check_outputs_zero("abort");
    exp_q.delete();
    rst       = 1'b0;
    cnt_model = '0;
    repeat (busy_len + 3) tick();
    do_dump();

    // Randomized command mix
    for (int it = 0; it < 25; it++) begin
      busy_len = $urandom_range(0, 4);
      dp_bus   = rand_bus();
      case ($urandom_range(0, 5))
        0:       do_step();
        1:       do_run($urandom_range(1, 20), 1'b0);
        2:       do_run($urandom_range(1, 20), 1'b1);
        3:       do_dump();
        4:       do_reset_cmd();
        default: do_junk();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
